// File: rtl/axis_weight_rotator.sv
// axis_weight_rotator
// Double-buffered weight store between the weight DMA stream and the
// convolution engine. One output channel's weight set (N beats) is captured
// into one half of the memory. It is then replayed R = cols*blocks times while
// the next set fills the other half.
//
// Ports
//   aclk, aresetn, aclken : clock, async active-low reset, clock enable
//   start                 : latch config, clear both buffers and the pipeline
//   kernel_h_1, cin_1     : set length N = (cin_1+1)*(kernel_h_1+1)
//   cols_1, blocks_1      : repetition count R = (cols_1+1)*(blocks_1+1)
//   s_valid/s_ready/s_data: fill stream
//   m_valid/m_ready/m_data: replay stream; m_last ends a repetition,
//                           m_done ends the final repetition of a set
//   config_error          : latched when N exceeds DEPTH
module axis_weight_rotator #(
    parameter int DATA_WIDTH           = 16,
    parameter int KERNEL_W_MAX         = 3,
    parameter int KERNEL_H_MAX         = 3,
    parameter int CIN_COUNTER_WIDTH    = 10,
    parameter int COLS_COUNTER_WIDTH   = 10,
    parameter int BLOCKS_COUNTER_WIDTH = 8,
    parameter int DEPTH                = 1024
) (
    input  logic                                aclk,
    input  logic                                aresetn,
    input  logic                                aclken,
    input  logic                                start,
    input  logic [$clog2(KERNEL_H_MAX+1)-1:0]   kernel_h_1,
    input  logic [CIN_COUNTER_WIDTH-1:0]        cin_1,
    input  logic [COLS_COUNTER_WIDTH-1:0]       cols_1,
    input  logic [BLOCKS_COUNTER_WIDTH-1:0]     blocks_1,
    input  logic                                s_valid,
    input  logic [DATA_WIDTH-1:0]               s_data [KERNEL_W_MAX],
    output logic                                s_ready,
    output logic                                m_valid,
    output logic [DATA_WIDTH-1:0]               m_data [KERNEL_W_MAX],
    input  logic                                m_ready,
    output logic                                m_last,
    output logic                                m_done,
    output logic                                config_error
);
    localparam int KH_WIDTH   = $clog2(KERNEL_H_MAX + 1);
    localparam int ADDR_WIDTH = $clog2(DEPTH);
    localparam int BEAT_W     = DATA_WIDTH * KERNEL_W_MAX;
    localparam int NW         = CIN_COUNTER_WIDTH + KH_WIDTH + 2;

    logic                            configured;
    logic [ADDR_WIDTH-1:0]           n_last;
    logic [COLS_COUNTER_WIDTH-1:0]   cols_r;
    logic [BLOCKS_COUNTER_WIDTH-1:0] blocks_r;
    logic [NW-1:0]                   n_prod;

    logic [1:0]            full;
    logic [1:0]            drained;    // final beat of this buffer already issued
    logic                  wr_sel;
    logic                  rd_sel;     // buffer owning the beat at the output
    logic                  iss_sel;    // buffer currently being read from memory
    logic [ADDR_WIDTH-1:0] wptr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic [COLS_COUNTER_WIDTH-1:0]   col_cnt;
    logic [BLOCKS_COUNTER_WIDTH-1:0] blk_cnt;

    logic [BEAT_W-1:0] mem [2*DEPTH];
    logic [BEAT_W-1:0] s_beat;
    logic [BEAT_W-1:0] p1_data;
    logic              p1_valid, p1_last, p1_done;
    logic [BEAT_W-1:0] skid_data;
    logic              skid_valid, skid_last, skid_done;
    logic [BEAT_W-1:0] out_data;

    logic start_en, fill_fire, fill_last, out_free, skid_valid_next;
    logic issue, iss_last_addr, iss_last_rep, done_accept;

    always_comb begin
        s_beat = '0;
        for (int unsigned i = 0; i < KERNEL_W_MAX; i++)
            s_beat[i*DATA_WIDTH +: DATA_WIDTH] = s_data[i];
    end

    always_comb begin
        for (int unsigned i = 0; i < KERNEL_W_MAX; i++)
            m_data[i] = out_data[i*DATA_WIDTH +: DATA_WIDTH];
    end

    always_comb begin
        n_prod          = (NW'(cin_1) + NW'(1)) * (NW'(kernel_h_1) + NW'(1));
        start_en        = start && aclken;
        s_ready         = configured && !config_error && !full[wr_sel];
        fill_fire       = aclken && !start && s_valid && s_ready;
        fill_last       = (wptr == n_last);
        out_free        = !m_valid || m_ready;
        skid_valid_next = out_free ? (skid_valid && p1_valid) : (skid_valid || p1_valid);
        // A read is only launched when the skid is guaranteed empty when its
        // data emerges, so the non-stallable memory output always has a home.
        issue           = aclken && !start && full[iss_sel] && !drained[iss_sel]
                          && !skid_valid_next;
        iss_last_addr   = (rd_addr == n_last);
        iss_last_rep    = (col_cnt == cols_r) && (blk_cnt == blocks_r);
        done_accept     = aclken && !start && m_valid && m_ready && m_done;
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            configured   <= 1'b0;
            config_error <= 1'b0;
            n_last       <= '0;
            cols_r       <= '0;
            blocks_r     <= '0;
        end else if (start_en) begin
            configured   <= 1'b1;
            config_error <= (n_prod > NW'(DEPTH));
            n_last       <= ADDR_WIDTH'(n_prod - NW'(1));
            cols_r       <= cols_1;
            blocks_r     <= blocks_1;
        end
    end

    always_ff @(posedge aclk) begin
        if (fill_fire)
            mem[{wr_sel, wptr}] <= s_beat;
        if (issue)
            p1_data <= mem[{iss_sel, rd_addr}];
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            wptr   <= '0;
            wr_sel <= 1'b0;
        end else if (start_en) begin
            wptr   <= '0;
            wr_sel <= 1'b0;
        end else if (fill_fire) begin
            if (fill_last) begin
                wptr   <= '0;
                wr_sel <= ~wr_sel;
            end else begin
                wptr <= wptr + 1'b1;
            end
        end
    end

    // Fill and drain always touch different buffers, so set and clear
    // never collide on the same flag.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            full    <= '0;
            drained <= '0;
            rd_sel  <= 1'b0;
        end else if (start_en) begin
            full    <= '0;
            drained <= '0;
            rd_sel  <= 1'b0;
        end else if (aclken) begin
            if (fill_fire && fill_last)
                full[wr_sel] <= 1'b1;
            if (issue && iss_last_addr && iss_last_rep)
                drained[iss_sel] <= 1'b1;
            if (done_accept) begin
                full[rd_sel]    <= 1'b0;
                drained[rd_sel] <= 1'b0;
                rd_sel          <= ~rd_sel;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            rd_addr <= '0;
            col_cnt <= '0;
            blk_cnt <= '0;
            iss_sel <= 1'b0;
        end else if (start_en) begin
            rd_addr <= '0;
            col_cnt <= '0;
            blk_cnt <= '0;
            iss_sel <= 1'b0;
        end else if (issue) begin
            if (iss_last_addr) begin
                rd_addr <= '0;
                if (iss_last_rep) begin
                    col_cnt <= '0;
                    blk_cnt <= '0;
                    iss_sel <= ~iss_sel;
                end else if (col_cnt == cols_r) begin
                    col_cnt <= '0;
                    blk_cnt <= blk_cnt + 1'b1;
                end else begin
                    col_cnt <= col_cnt + 1'b1;
                end
            end else begin
                rd_addr <= rd_addr + 1'b1;
            end
        end
    end

    // Output register plus one-entry skid; the skid always holds the older beat.
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            p1_valid   <= 1'b0;
            p1_last    <= 1'b0;
            p1_done    <= 1'b0;
            skid_valid <= 1'b0;
            skid_last  <= 1'b0;
            skid_done  <= 1'b0;
            skid_data  <= '0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_done     <= 1'b0;
            out_data   <= '0;
        end else if (start_en) begin
            p1_valid   <= 1'b0;
            skid_valid <= 1'b0;
            m_valid    <= 1'b0;
            m_last     <= 1'b0;
            m_done     <= 1'b0;
        end else if (aclken) begin
            p1_valid <= issue;
            p1_last  <= iss_last_addr;
            p1_done  <= iss_last_addr && iss_last_rep;
            if (out_free) begin
                if (skid_valid) begin
                    m_valid    <= 1'b1;
                    out_data   <= skid_data;
                    m_last     <= skid_last;
                    m_done     <= skid_done;
                    skid_valid <= p1_valid;
                    if (p1_valid) begin
                        skid_data <= p1_data;
                        skid_last <= p1_last;
                        skid_done <= p1_done;
                    end
                end else if (p1_valid) begin
                    m_valid  <= 1'b1;
                    out_data <= p1_data;
                    m_last   <= p1_last;
                    m_done   <= p1_done;
                end else begin
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                    m_done  <= 1'b0;
                end
            end else if (p1_valid) begin
                skid_valid <= 1'b1;
                skid_data  <= p1_data;
                skid_last  <= p1_last;
                skid_done  <= p1_done;
            end
        end
    end
endmodule

// File: tb/tb_axis_weight_rotator.sv
module tb_axis_weight_rotator;
    localparam int DW = 16;
    localparam int KW = 3;

    logic          aclk = 1'b0;
    logic          aresetn = 1'b0;
    logic          aclken = 1'b1;
    logic          start = 1'b0;
    logic [1:0]    kernel_h_1 = '0;
    logic [9:0]    cin_1 = '0;
    logic [9:0]    cols_1 = '0;
    logic [7:0]    blocks_1 = '0;
    logic          s_valid = 1'b0;
    logic [DW-1:0] s_data [KW];
    logic          s_ready;
    logic          m_valid;
    logic [DW-1:0] m_data [KW];
    logic          m_ready = 1'b1;
    logic          m_last;
    logic          m_done;
    logic          config_error;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;

    typedef struct {
        logic [47:0] d;
        logic        last;
        logic        done;
        int          cyc;
    } beat_t;
    beat_t outq[$];

    int first_valid_cyc = -1;
    int valid_seen = 0;
    int stall_viol = 0;
    bit chk_stall = 1'b0;
    int rdy_mode = 0;

    axis_weight_rotator #(
        .DATA_WIDTH(16), .KERNEL_W_MAX(3), .KERNEL_H_MAX(3),
        .CIN_COUNTER_WIDTH(10), .COLS_COUNTER_WIDTH(10),
        .BLOCKS_COUNTER_WIDTH(8), .DEPTH(1024)
    ) dut (
        .aclk(aclk), .aresetn(aresetn), .aclken(aclken), .start(start),
        .kernel_h_1(kernel_h_1), .cin_1(cin_1), .cols_1(cols_1), .blocks_1(blocks_1),
        .s_valid(s_valid), .s_data(s_data), .s_ready(s_ready),
        .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready),
        .m_last(m_last), .m_done(m_done), .config_error(config_error)
    );

    always #5 aclk = ~aclk;

    initial forever begin
        @(posedge aclk);
        cyc++;
    end

    initial forever begin
        @(posedge aclk);
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = ($urandom_range(0, 1) == 1);
            default: m_ready = 1'b0;
        endcase
    end

    // Output collector: records every beat that will be accepted at the next edge.
    initial begin : monitor
        logic [47:0] cur;
        logic [47:0] prev_d;
        logic        prev_last, prev_done, prev_stall;
        prev_stall = 1'b0;
        prev_d = '0; prev_last = 1'b0; prev_done = 1'b0;
        forever begin
            @(negedge aclk);
            if (aresetn) begin
                cur = {m_data[2], m_data[1], m_data[0]};
                if (m_valid) begin
                    valid_seen++;
                    if (first_valid_cyc < 0) first_valid_cyc = cyc;
                end
                if (chk_stall && prev_stall &&
                    (!m_valid || cur !== prev_d || m_last !== prev_last || m_done !== prev_done))
                    stall_viol++;
                prev_stall = m_valid && !m_ready;
                prev_d = cur; prev_last = m_last; prev_done = m_done;
                if (m_valid && m_ready)
                    outq.push_back('{d: cur, last: m_last, done: m_done, cyc: cyc});
            end else begin
                prev_stall = 1'b0;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
        $fatal(1);
    end

    // {last, done, data} expected for beat i of one set expansion (n beats, reps repetitions)
    function automatic logic [49:0] exp_beat(input int base, input int i, input int n, input int reps);
        int b;
        logic [47:0] d;
        b = i % n;
        for (int j = 0; j < KW; j++) d[j*16 +: 16] = 16'(base + 3*b + j);
        return {(b == n-1), (i == n*reps-1), d};
    endfunction

    task automatic do_start(input logic [1:0] kh, input logic [9:0] ci,
                            input logic [9:0] co, input logic [7:0] bl);
        kernel_h_1 = kh; cin_1 = ci; cols_1 = co; blocks_1 = bl;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
    endtask

    task automatic drive_fill(input int base, input int n, input bit rnd, input int maxcyc,
                              output int nacc, output int last_cyc);
        int k = 0;
        int t = 0;
        bit acc;
        last_cyc = -1;
        while (k < n && t < maxcyc) begin
            s_valid = rnd ? ($urandom_range(0, 1) == 1) : 1'b1;
            for (int j = 0; j < KW; j++) s_data[j] = DW'(base + 3*k + j);
            @(negedge aclk);
            acc = s_valid && s_ready;
            @(posedge aclk); #1;
            if (acc) begin
                k++;
                last_cyc = cyc;
            end
            t++;
        end
        s_valid = 1'b0;
        nacc = k;
    endtask

    task automatic wait_beats(input int n, input int maxcyc);
        int t = 0;
        while (outq.size() < n && t < maxcyc) begin
            @(negedge aclk);
            t++;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge aclk);
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_ready: got %b expected 0", s_ready); end
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL reset_m_valid: got %b expected 0", m_valid); end
        vectors++; if ({m_last, m_done} !== 2'b00) begin miscompares++; $display("FAIL reset_last_done: got %b expected 00", {m_last, m_done}); end
        vectors++; if (config_error !== 1'b0) begin miscompares++; $display("FAIL reset_config_error: got %b expected 0", config_error); end
        vectors++; if ({m_data[2], m_data[1], m_data[0]} !== 48'h0) begin miscompares++; $display("FAIL reset_m_data: got %h expected 0", {m_data[2], m_data[1], m_data[0]}); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (3) @(negedge aclk);
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL unconfigured_s_ready: got %b expected 0", s_ready); end
        @(posedge aclk); #1;
    endtask

    task automatic test_single_set;
        int nacc, lc;
        logic [49:0] e;
        rdy_mode = 0;
        do_start(2'd2, 10'd2, 10'd3, 8'd0);
        outq.delete();
        first_valid_cyc = -1;
        drive_fill(1, 9, 1'b0, 50, nacc, lc);
        vectors++; if (nacc !== 9) begin miscompares++; $display("FAIL single_fill_count: got %0d expected 9", nacc); end
        wait_beats(36, 200);
        repeat (4) @(negedge aclk);
        vectors++; if (outq.size() !== 36) begin miscompares++; $display("FAIL single_beat_count: got %0d expected 36", outq.size()); end
        for (int i = 0; i < outq.size() && i < 36; i++) begin
            e = exp_beat(1, i, 9, 4);
            vectors++;
            if ({outq[i].last, outq[i].done, outq[i].d} !== e) begin
                miscompares++;
                $display("FAIL single_beat[%0d]: got %h expected %h", i, {outq[i].last, outq[i].done, outq[i].d}, e);
            end
        end
        vectors++; if (first_valid_cyc !== lc + 2) begin miscompares++; $display("FAIL single_latency: got cycle %0d expected %0d", first_valid_cyc, lc + 2); end
        if (outq.size() >= 36) begin
            vectors++;
            if (outq[35].cyc - outq[0].cyc !== 35) begin miscompares++; $display("FAIL single_contiguous: got span %0d expected 35", outq[35].cyc - outq[0].cyc); end
        end
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL single_s_ready_after: got %b expected 1", s_ready); end
        @(posedge aclk); #1;
    endtask

    task automatic test_back_to_back;
        int na1, na2, lc;
        logic [49:0] e;
        rdy_mode = 0;
        do_start(2'd2, 10'd2, 10'd3, 8'd0);
        outq.delete();
        drive_fill(1, 9, 1'b0, 50, na1, lc);
        drive_fill(101, 9, 1'b0, 50, na2, lc);
        @(negedge aclk);
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL b2b_s_ready_both_full: got %b expected 0", s_ready); end
        vectors++; if (na1 + na2 !== 18) begin miscompares++; $display("FAIL b2b_fill_count: got %0d expected 18", na1 + na2); end
        wait_beats(72, 300);
        repeat (4) @(negedge aclk);
        vectors++; if (outq.size() !== 72) begin miscompares++; $display("FAIL b2b_beat_count: got %0d expected 72", outq.size()); end
        for (int i = 0; i < outq.size() && i < 72; i++) begin
            e = exp_beat((i >= 36) ? 101 : 1, i % 36, 9, 4);
            vectors++;
            if ({outq[i].last, outq[i].done, outq[i].d} !== e) begin
                miscompares++;
                $display("FAIL b2b_beat[%0d]: got %h expected %h", i, {outq[i].last, outq[i].done, outq[i].d}, e);
            end
        end
        if (outq.size() >= 72) begin
            vectors++;
            if (outq[71].cyc - outq[0].cyc !== 71) begin miscompares++; $display("FAIL b2b_contiguous: got span %0d expected 71", outq[71].cyc - outq[0].cyc); end
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_random;
        int na, tot, lc;
        int bases [3];
        logic [49:0] e;
        bases[0] = 1; bases[1] = 201; bases[2] = 401;
        tot = 0;
        do_start(2'd2, 10'd2, 10'd3, 8'd0);
        outq.delete();
        stall_viol = 0;
        chk_stall = 1'b1;
        rdy_mode = 1;
        for (int s = 0; s < 3; s++) begin
            drive_fill(bases[s], 9, 1'b1, 2000, na, lc);
            tot += na;
        end
        vectors++; if (tot !== 27) begin miscompares++; $display("FAIL random_fill_count: got %0d expected 27", tot); end
        wait_beats(108, 4000);
        rdy_mode = 0;
        repeat (4) @(negedge aclk);
        chk_stall = 1'b0;
        vectors++; if (outq.size() !== 108) begin miscompares++; $display("FAIL random_beat_count: got %0d expected 108", outq.size()); end
        for (int i = 0; i < outq.size() && i < 108; i++) begin
            e = exp_beat(bases[i / 36], i % 36, 9, 4);
            vectors++;
            if ({outq[i].last, outq[i].done, outq[i].d} !== e) begin
                miscompares++;
                $display("FAIL random_beat[%0d]: got %h expected %h", i, {outq[i].last, outq[i].done, outq[i].d}, e);
            end
        end
        vectors++; if (stall_viol !== 0) begin miscompares++; $display("FAIL random_stall_stable: got %0d violations expected 0", stall_viol); end
        @(posedge aclk); #1;
    endtask

    task automatic test_config_error;
        int nacc, lc;
        logic [49:0] e;
        rdy_mode = 0;
        do_start(2'd2, 10'd511, 10'd0, 8'd0);
        @(negedge aclk);
        vectors++; if (config_error !== 1'b1) begin miscompares++; $display("FAIL cfgerr_flag: got %b expected 1", config_error); end
        vectors++; if (s_ready !== 1'b0) begin miscompares++; $display("FAIL cfgerr_s_ready: got %b expected 0", s_ready); end
        @(posedge aclk); #1;
        valid_seen = 0;
        outq.delete();
        drive_fill(1, 9, 1'b0, 20, nacc, lc);
        vectors++; if (nacc !== 0) begin miscompares++; $display("FAIL cfgerr_accepted: got %0d expected 0", nacc); end
        vectors++; if (valid_seen !== 0) begin miscompares++; $display("FAIL cfgerr_m_valid: got %0d valid cycles expected 0", valid_seen); end
        do_start(2'd2, 10'd2, 10'd0, 8'd0);
        @(negedge aclk);
        vectors++; if (config_error !== 1'b0) begin miscompares++; $display("FAIL cfgok_flag: got %b expected 0", config_error); end
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL cfgok_s_ready: got %b expected 1", s_ready); end
        @(posedge aclk); #1;
        drive_fill(1, 9, 1'b0, 50, nacc, lc);
        wait_beats(9, 100);
        repeat (4) @(negedge aclk);
        vectors++; if (outq.size() !== 9) begin miscompares++; $display("FAIL cfgok_beat_count: got %0d expected 9", outq.size()); end
        for (int i = 0; i < outq.size() && i < 9; i++) begin
            e = exp_beat(1, i, 9, 1);
            vectors++;
            if ({outq[i].last, outq[i].done, outq[i].d} !== e) begin
                miscompares++;
                $display("FAIL cfgok_beat[%0d]: got %h expected %h", i, {outq[i].last, outq[i].done, outq[i].d}, e);
            end
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_start_mid;
        int nacc, lc;
        logic [49:0] e;
        rdy_mode = 0;
        do_start(2'd2, 10'd2, 10'd3, 8'd0);
        outq.delete();
        drive_fill(1, 9, 1'b0, 50, nacc, lc);
        wait_beats(12, 100);
        vectors++; if (outq.size() < 12) begin miscompares++; $display("FAIL midstart_reached_rep2: got %0d beats expected >=12", outq.size()); end
        @(posedge aclk); #1;
        start = 1'b1;
        @(posedge aclk); #1;
        start = 1'b0;
        @(negedge aclk);
        vectors++; if (m_valid !== 1'b0) begin miscompares++; $display("FAIL midstart_m_valid: got %b expected 0", m_valid); end
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL midstart_s_ready: got %b expected 1", s_ready); end
        outq.delete();
        @(posedge aclk); #1;
        drive_fill(301, 9, 1'b0, 50, nacc, lc);
        wait_beats(36, 200);
        repeat (4) @(negedge aclk);
        vectors++; if (outq.size() !== 36) begin miscompares++; $display("FAIL midstart_beat_count: got %0d expected 36", outq.size()); end
        for (int i = 0; i < outq.size() && i < 36; i++) begin
            e = exp_beat(301, i, 9, 4);
            vectors++;
            if ({outq[i].last, outq[i].done, outq[i].d} !== e) begin
                miscompares++;
                $display("FAIL midstart_beat[%0d]: got %h expected %h", i, {outq[i].last, outq[i].done, outq[i].d}, e);
            end
        end
        @(posedge aclk); #1;
    endtask

    task automatic test_async_reset;
        int nacc, lc;
        int sr = 0;
        rdy_mode = 0;
        do_start(2'd2, 10'd2, 10'd3, 8'd0);
        drive_fill(1, 4, 1'b0, 50, nacc, lc);
        vectors++; if (s_ready !== 1'b1) begin miscompares++; $display("FAIL arst_fill_pre: got %b expected 1", s_ready); end
        #2;
        aresetn = 1'b0;
        #1;
        vectors++; if ({s_ready, m_valid, config_error} !== 3'b000) begin miscompares++; $display("FAIL arst_midfill: got %b expected 000", {s_ready, m_valid, config_error}); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        do_start(2'd2, 10'd2, 10'd3, 8'd0);
        outq.delete();
        drive_fill(1, 9, 1'b0, 50, nacc, lc);
        wait_beats(5, 100);
        @(posedge aclk); #3;
        vectors++; if (m_valid !== 1'b1) begin miscompares++; $display("FAIL arst_replay_pre: got %b expected 1", m_valid); end
        aresetn = 1'b0;
        #1;
        vectors++; if ({m_valid, m_last, m_done, s_ready} !== 4'b0000) begin miscompares++; $display("FAIL arst_midreplay_ctl: got %b expected 0000", {m_valid, m_last, m_done, s_ready}); end
        vectors++; if ({m_data[2], m_data[1], m_data[0]} !== 48'h0) begin miscompares++; $display("FAIL arst_midreplay_data: got %h expected 0", {m_data[2], m_data[1], m_data[0]}); end
        @(posedge aclk); #1;
        aresetn = 1'b1;
        repeat (5) begin
            @(negedge aclk);
            if (s_ready) sr++;
        end
        vectors++; if (sr !== 0) begin miscompares++; $display("FAIL arst_unconfigured: got %0d ready cycles expected 0", sr); end
        @(posedge aclk); #1;
    endtask

    initial begin
        for (int j = 0; j < KW; j++) s_data[j] = '0;
        test_reset();
        test_single_set();
        test_back_to_back();
        test_random();
        test_config_error();
        test_start_mid();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/axis_weight_rotator.md
# axis_weight_rotator

Double-buffered AXI-Stream weight buffer that sits between the weight DMA stream and the convolution engine's weight input. It captures one output channel's weight set (cin × kernel_h beats, KERNEL_W_MAX words each) and replays it once per column per block, so the engine sees the same weights for every column and block. While one set is being replayed, the next set fills the second buffer, giving gapless channel-to-channel streaming.

## Interface
- DATA_WIDTH, 16, width of one weight word
- KERNEL_W_MAX, 3, words per beat
- KERNEL_H_MAX, 3, maximum kernel height (odd)
- CIN_COUNTER_WIDTH, 10, width of cin_1
- COLS_COUNTER_WIDTH, 10, width of cols_1
- BLOCKS_COUNTER_WIDTH, 8, width of blocks_1
- DEPTH, 1024, beats per buffer (power of 2); ADDR_WIDTH = clog2(DEPTH)

- aclk  in  1  single clock, all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- aclken  in  1  clock enable; low freezes all state and ignores handshakes
- start  in  1  one-cycle pulse: latch config, clear both buffers
- kernel_h_1  in  clog2(KERNEL_H_MAX+1)  kernel height − 1
- cin_1  in  CIN_COUNTER_WIDTH  input channels − 1
- cols_1  in  COLS_COUNTER_WIDTH  image columns − 1
- blocks_1  in  BLOCKS_COUNTER_WIDTH  row blocks − 1
- s_valid  in  1  input beat valid
- s_data  in  KERNEL_W_MAX × DATA_WIDTH  input weight beat (unpacked array)
- s_ready  out  1  fill buffer can accept
- m_valid  out  1  output beat valid
- m_data  out  KERNEL_W_MAX × DATA_WIDTH  output weight beat
- m_ready  in  1  downstream accepts
- m_last  out  1  final beat of one repetition
- m_done  out  1  final beat of final repetition of a set
- config_error  out  1  N exceeds DEPTH

## Operation
- N = (cin_1+1)·(kernel_h_1+1) beats per set; R = (cols_1+1)·(blocks_1+1) repetitions, realised as nested col/block counters (no multiplier).
- Config latched on start; applies to every set until the next start. Before the first start, s_ready = 0.
- If N > DEPTH at start: config_error = 1, s_ready held 0, no output, until the next start with valid N.
- Fill side: a write pointer addresses buffer wr_sel. Each s_valid&&s_ready beat writes at address wptr. On beat N−1, full[wr_sel] is set, wptr returns to 0, and wr_sel toggles. s_ready = configured && !config_error && !full[wr_sel].
- Read side: when full[rd_sel] is set, replay addresses 0..N−1, R times. m_last is set on address N−1. m_done is set on address N−1 of repetition R−1. On acceptance of the m_done beat, full[rd_sel] is cleared and rd_sel toggles.
- Buffer memory has a synchronous 1-cycle read. The output stage is an output register plus a one-entry skid, so no beat is lost or duplicated under any m_ready pattern.
- Simultaneous events:
  - Fill completing on the same cycle the reader frees the other buffer: both flag updates take effect.
  - Fill completing on the same edge the reader's buffer is freed: no conflict, because the flags are separate.
  - start mid-operation has priority over everything: both full flags, pointers and counters clear; m_valid drops the next cycle; the skid is flushed; in-flight beats are discarded.
- Reset: s_ready, m_valid, m_last, m_done and config_error are 0. m_data is 0, pointers are 0, wr_sel = rd_sel = 0, full flags are 0, and the block is unconfigured.

## Timing
- Fill accepts 1 beat/cycle while s_ready is high.
- Last fill beat accepted at edge T: full set at T, first read issued at T+1, m_valid high after T+2 (latency 2).
- With m_ready held high, output is 1 beat/cycle with no bubble between repetitions. There is also no bubble between sets when the next buffer is already full at the m_done acceptance.
- m_last and m_done are aligned with their m_data beat. m_data, m_last and m_done are held stable while m_valid && !m_ready.
- aclken low: no state changes; m_valid and m_data hold.

## Test plan
- Config kernel_h_1=2, cin_1=2, cols_1=3, blocks_1=0; stream N=9 beats of values 1..27 → 36 output beats repeating 1..27 four times; m_last on beats 9,18,27,36; m_done only on beat 36; first m_valid 2 cycles after the 9th fill.
- Two sets back-to-back (values 1..27, then 101..127) with m_ready always 1 → set 2 fills during set 1 replay; 72 contiguous output beats, no bubble at the transition; s_ready low once both buffers are full.
- Random m_ready (50%) and random s_valid over 3 sets → output sequence equals the reference expansion exactly; no drop or duplicate; data stable while stalled.
- cin_1=511, kernel_h_1=2 (N=1536 > DEPTH=1024) → config_error=1, s_ready=0, no m_valid; next start with cin_1=2 → config_error=0, normal operation.
- start pulse mid-replay (repetition 2 of 4) → m_valid=0 next cycle, both buffers empty, s_ready=1; a new set replays from beat 0.
- aresetn asserted mid-fill and mid-replay → all outputs 0 immediately (asynchronous); after release s_ready=0 until start.
